opb_register_ppc2simulink: RTL and testbench

OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

---
 rtl/opb_register_ppc2simulink.sv | 125 ++++++++++++
 tb/tb_opb_register_ppc2simulink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module      : opb_register_ppc2simulink
// Description : OPB slave holding one byte-writable register handed to fabric,
//               with a STATUS word of write count and a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module opb_register_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01094E00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01094EFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [31:0]               user_data_out,
    output logic                      user_data_valid,
    input  logic                      user_data_ack
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_ack  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    localparam c_family_unused = C_FAMILY;

    logic [1:0]  r_state;
    logic        r_rnw;
    logic        r_is_status;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_user_data;
    logic        r_valid;
    logic [15:0] r_write_count;

    logic        w_hit;
    logic        w_data_wr;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = OPB_seqAddr;

    assign w_hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

    // Transfer attributes are captured on the hit so the ACK cycle does not
    // depend on the master holding the bus stable.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state     <= c_st_idle;
            r_rnw       <= 1'b0;
            r_is_status <= 1'b0;
            r_be        <= 4'b0;
            r_wdata     <= 32'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_hit) begin
                        r_state     <= c_st_ack;
                        r_rnw       <= OPB_RNW;
                        r_is_status <= OPB_ABus[C_OPB_AWIDTH-3];
                        r_be        <= OPB_BE;
                        r_wdata     <= OPB_DBus;
                    end
                end
                c_st_ack:  r_state <= c_st_wait;
                c_st_wait: begin
                    if (!OPB_select) begin
                        r_state <= c_st_idle;
                    end
                end
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign w_data_wr = (r_state == c_st_ack) && !r_rnw && !r_is_status && (r_be != 4'b0);

    // r_be[i] enables r_wdata[8i+:8]; a write beats a coincident fabric ack.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_user_data   <= 32'b0;
            r_valid       <= 1'b0;
            r_write_count <= 16'b0;
        end else if (w_data_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_user_data[8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
            r_valid       <= 1'b1;
            r_write_count <= r_write_count + 16'd1;
        end else if (user_data_ack) begin
            r_valid <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 32'b0;
        if ((r_state == c_st_ack) && r_rnw) begin
            w_rdata = r_is_status ? {r_write_count, 15'b0, r_valid} : r_user_data;
        end
    end

    assign Sl_DBus         = w_rdata;
    assign Sl_xferAck      = (r_state == c_st_ack);
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = r_user_data;
    assign user_data_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module      : tb_opb_register_ppc2simulink
// Description : Self-checking bench; read data is scoreboarded against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opb_register_ppc2simulink;

    localparam logic [31:0] c_base = 32'h01094E00;
    localparam logic [31:0] c_high = 32'h01094EFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] abus = '0;
    logic [3:0]  be_s = '0;
    logic [31:0] dbus = '0;
    logic        rnw_s = 1'b0;
    logic        select_s = 1'b0;
    logic        seqaddr = 1'b0;
    logic        uack = 1'b0;
    logic [31:0] sl_dbus;
    logic        xfer_ack, err_ack, retry, tout_sup;
    logic [31:0] udo;
    logic        uvalid;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] q_exp[$];
    logic [31:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_count = '0;

    always #5 clk = ~clk;

    opb_register_ppc2simulink dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (abus),
        .OPB_BE         (be_s),
        .OPB_DBus       (dbus),
        .OPB_RNW        (rnw_s),
        .OPB_select     (select_s),
        .OPB_seqAddr    (seqaddr),
        .Sl_DBus        (sl_dbus),
        .Sl_xferAck     (xfer_ack),
        .Sl_errAck      (err_ack),
        .Sl_retry       (retry),
        .Sl_toutSup     (tout_sup),
        .user_data_out  (udo),
        .user_data_valid(uvalid),
        .user_data_ack  (uack)
    );

    // One transfer; checks ack count/latency and pops expected read data on ack.
    task automatic bus_xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                            input logic [31:0] data, input int hold, input bit exp_ack,
                            input bit coll, input string name);
        int acks = 0;
        int first = -1;
        logic [31:0] exp;
        @(posedge clk); #1;
        abus = addr; rnw_s = rnw; be_s = be; dbus = data; select_s = 1'b1;
        for (int c = 0; c < 2 + hold; c++) begin
            @(negedge clk);
            if (xfer_ack === 1'b1) begin
                acks++;
                if (first < 0) first = c;
                n_compared++;
                if (rnw) begin
                    if (q_exp.size() == 0) begin
                        n_mismatched++;
                        $display("FAIL %s: read ack with data %h but nothing expected", name, sl_dbus);
                    end else begin
                        exp = q_exp.pop_front();
                        if (sl_dbus !== exp) begin
                            n_mismatched++;
                            $display("FAIL %s: read data got %h expected %h", name, sl_dbus, exp);
                        end
                    end
                end else if (sl_dbus !== 32'h0) begin
                    n_mismatched++;
                    $display("FAIL %s: Sl_DBus during write ack got %h expected 00000000", name, sl_dbus);
                end
                if (coll) uack = 1'b1;
            end
        end
        select_s = 1'b0;
        @(posedge clk); #1;
        uack = 1'b0;
        @(posedge clk); #1;
        n_compared++;
        if (exp_ack ? (acks != 1 || first != 1) : (acks != 0)) begin
            n_mismatched++;
            $display("FAIL %s: ack count %0d at cycle %0d, expected %0d at cycle 1",
                     name, acks, first, exp_ack ? 1 : 0);
        end
        q_exp.delete();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input bit coll, input string name);
        logic [31:0] mask = '0;
        bus_xfer(addr, 1'b0, be, data, 0, 1'b1, coll, name);
        if (addr[2] == 1'b0 && be != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (be[3-i]) mask[31-8*i -: 8] = 8'hFF;
            m_data  = (m_data & ~mask) | (data & mask);
            m_valid = 1'b1;
            m_count = m_count + 16'd1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold, input string name);
        q_exp.push_back(addr[2] ? {m_count, 15'b0, m_valid} : m_data);
        bus_xfer(addr, 1'b1, 4'hF, 32'h0, hold, 1'b1, 1'b0, name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_compared++;
        if ({xfer_ack, err_ack, retry, tout_sup, uvalid} !== 5'b0 || sl_dbus !== 32'h0 || udo !== 32'h0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: ack/err/retry/tout/valid=%b dbus=%h udo=%h expected all 0",
                     {xfer_ack, err_ack, retry, tout_sup, uvalid}, sl_dbus, udo);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_data = '0; m_valid = 1'b0; m_count = '0;
        do_read(c_base, 0, "reset_read_data");
        do_read(c_base + 32'h4, 0, "reset_read_status");
    endtask

    task automatic test_write;
        do_write(c_base, 4'b1111, 32'hDEADBEEF, 1'b0, "write_full");
        n_compared++;
        if (udo !== 32'hDEADBEEF || uvalid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL write_full_out: udo=%h valid=%b expected DEADBEEF/1", udo, uvalid);
        end
        do_read(c_base + 32'h4, 0, "status_after_one");
        do_write(c_base, 4'b0101, 32'h11223344, 1'b0, "write_partial");
        n_compared++;
        if (udo !== 32'hDE22BE44) begin
            n_mismatched++;
            $display("FAIL write_partial_out: udo=%h expected DE22BE44", udo);
        end
        do_write(c_base, 4'b0000, 32'hFFFFFFFF, 1'b0, "write_be0");
        do_write(c_base + 32'h4, 4'b1111, 32'h55555555, 1'b0, "write_status");
        do_read(c_base, 0, "read_data_partial");
        do_read(c_base + 32'h4, 0, "status_after_noop");
    endtask

    task automatic test_ack_handshake;
        do_write(c_base, 4'b1111, 32'h0BADCAFE, 1'b1, "write_ack_collision");
        n_compared++;
        if (uvalid !== 1'b1 || udo !== 32'h0BADCAFE) begin
            n_mismatched++;
            $display("FAIL collision: valid=%b udo=%h expected 1/0BADCAFE", uvalid, udo);
        end
        @(posedge clk); #1 uack = 1'b1;
        @(negedge clk);
        n_compared++;
        if (uvalid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL ack_early: valid=%b expected 1 before edge", uvalid);
        end
        @(posedge clk); #1 uack = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (uvalid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL lone_ack: valid=%b expected 0", uvalid);
        end
        @(posedge clk); #1 uack = 1'b1;
        @(posedge clk); #1 uack = 1'b0;
        n_compared++;
        if (uvalid !== 1'b0 || udo !== m_data) begin
            n_mismatched++;
            $display("FAIL idle_ack: valid=%b udo=%h expected 0/%h", uvalid, udo, m_data);
        end
        do_read(c_base + 32'h4, 0, "status_after_ack");
    endtask

    task automatic test_wrap;
        @(posedge clk); #1;
        force dut.r_write_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_write_count;
        m_count = 16'hFFFE;
        do_write(c_base, 4'b1000, 32'hA5000000, 1'b0, "write_to_ffff");
        do_read(c_base + 32'h4, 0, "status_ffff");
        do_write(c_base, 4'b0001, 32'h0000005A, 1'b0, "write_wrap");
        do_read(c_base + 32'h4, 0, "status_wrapped");
    endtask

    task automatic test_reset_in_ack;
        @(posedge clk); #1;
        abus = c_base; rnw_s = 1'b0; be_s = 4'hF; dbus = 32'hCAFEF00D; select_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (xfer_ack !== 1'b1) begin
            n_mismatched++;
            $display("FAIL rst_ack_pre: ack=%b expected 1", xfer_ack);
        end
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (xfer_ack !== 1'b0 || sl_dbus !== 32'h0 || udo !== 32'h0 || uvalid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL async_reset: ack=%b dbus=%h udo=%h valid=%b expected 0", xfer_ack, sl_dbus, udo, uvalid);
        end
        select_s = 1'b0;
        @(posedge clk); #1;
        n_compared++;
        if (udo !== 32'h0 || xfer_ack !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_abort: udo=%h ack=%b expected 0/0", udo, xfer_ack);
        end
        rst_n = 1'b1;
        m_data = '0; m_valid = 1'b0; m_count = '0;
        do_read(c_base + 32'h4, 0, "post_reset_status");
        do_read(c_base, 0, "post_reset_data");
    endtask

    task automatic test_range_and_hold;
        bus_xfer(c_high + 32'h1, 1'b1, 4'hF, 32'h0, 0, 1'b0, 1'b0, "oor_high");
        bus_xfer(c_base - 32'h4, 1'b0, 4'hF, 32'h12345678, 0, 1'b0, 1'b0, "oor_low");
        n_compared++;
        if (udo !== m_data || uvalid !== m_valid) begin
            n_mismatched++;
            $display("FAIL oor_no_effect: udo=%h valid=%b expected %h/%b", udo, uvalid, m_data, m_valid);
        end
        do_read(32'h01094EFC, 0, "status_alias_top");
        do_write(c_base, 4'b1111, 32'h87654321, 1'b0, "write_before_hold");
        do_read(c_base, 10, "held_select");
    endtask

    initial begin
        test_reset();
        test_write();
        test_ack_handshake();
        test_wrap();
        test_reset_in_ack();
        test_range_and_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
